mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: RAM depth in 32-bit words; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 2: added wait states per access, 0..15.
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 memory_en  in  1  access request from the core.
REQ-006 store_size  in  2  access type: 00 byte write, 01 half write, 10 word write, 11 read.
REQ-007 mem_addr  in  32  byte address.
REQ-008 mem_write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 mem_read_data  out  32  read data, shifted right so the addressed byte sits in [7:0].
REQ-010 stall_mem  out  1  core must hold its request and PC while high.
REQ-011 misalign_err  out  1  one-cycle misaligned-access flag.

Function
REQ-012 FSM states: IDLE, WAIT, DONE.
REQ-013 IDLE with memory_en=1: stall_mem=1 combinationally in the same cycle.
REQ-014 IDLE with memory_en=1: latch mem_addr, store_size and mem_write_data; load the down-counter with WAIT_CYCLES.
REQ-015 IDLE with memory_en=1: go to WAIT if WAIT_CYCLES>0, else to DONE.
REQ-016 WAIT: stall_mem=1; decrement the counter each cycle; go to DONE on the edge where the counter equals 0.
REQ-017 Changes on the request inputs during WAIT or DONE are ignored; only latched values are used.
REQ-018 On the edge entering DONE:
- a write updates the enabled byte lanes of RAM word latched_addr[log2(DEPTH_WORDS)+1:2];
- a read registers the shifted RAM word into mem_read_data.
REQ-019 Byte lanes: byte uses lane addr[1:0]; half uses lanes {addr[1],0} and {addr[1],1}; word uses all four lanes.
REQ-020 Read shift: right shift by 8*addr[1:0] with zero fill.
REQ-021 DONE: stall_mem=0; mem_read_data valid for reads; always go to IDLE on the next edge.
REQ-022 mem_read_data holds its value until the next read reaches DONE; it is unchanged by writes.
REQ-023 Total stall per access is WAIT_CYCLES+1 cycles; the core completes the instruction in the DONE cycle.
REQ-024 Address bits above log2(DEPTH_WORDS)+1 are ignored, so the address space wraps (aliases) modulo 4*DEPTH_WORDS bytes.
REQ-025 IDLE with memory_en=0: stall_mem=0; no RAM activity.
REQ-026 A request is never accepted outside IDLE; back-to-back accesses are separated by the DONE cycle.

Reset
REQ-027 Reset forces state IDLE, counter 0, mem_read_data 0, misalign_err 0, and latched request registers 0.
REQ-028 stall_mem is 0 while reset is high.
REQ-029 RAM contents are not reset.
REQ-030 Reset asserted in WAIT aborts the access; a write not yet at the DONE-entry edge is never committed.

Configuration
REQ-031 Macro MEM_RESPONDER_ALIGN_CHECK_EN defined: misaligned accesses are detected.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- A misaligned access performs no RAM write, loads mem_read_data with 0, and pulses misalign_err=1 in the DONE cycle.
- Stall timing is unchanged.
REQ-032 Macro not defined: misalign_err is tied to 0.
- Half accesses ignore addr[0]; word accesses ignore addr[1:0].
- The access is performed at the aligned-down address.

Verification
REQ-033 WAIT_CYCLES=2. Word write 0xDEADBEEF to 0x10, then read 0x10 -> stall_mem high 3 cycles each; read returns 0xDEADBEEF in DONE.
REQ-034 Word 0x11223344 stored at 0x20. Byte write 0xAA to 0x22, then word read 0x20 -> 0x11AA3344; byte read 0x23 -> 0x00000011.
REQ-035 WAIT_CYCLES=0 -> IDLE->DONE; stall_mem high exactly 1 cycle; read-after-write to the same address returns the new data.
REQ-036 DEPTH_WORDS=256. Write 0x5 to 0x400, then read 0x0 -> 0x00000005 (wrap-around).
REQ-037 Reset pulsed during WAIT of a word write to 0x30 holding 0x0 -> later read of 0x30 returns 0x0; stall_mem low during reset.
REQ-038 With MEM_RESPONDER_ALIGN_CHECK_EN: half write to 0x31 -> misalign_err=1 for one cycle, RAM unchanged, read data 0.
- Without the macro: the same write updates lanes 0..1 of word 0x30.

Source files
------------

// File: rtl/mem_responder.sv
// Wait-stated single-port word RAM that answers core loads/stores with a stall handshake.
// Optional misaligned-access detection is enabled by defining MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        memory_en,
    input  logic [1:0]  store_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        stall_mem,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_READ = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        accept, stall, commit;

    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  acc_size;
    logic [AW-1:0] widx;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic        is_read, misaligned, do_write;
    logic [31:0] rd_shifted;

    logic [31:0] ram [DEPTH_WORDS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memory_en) begin
                    stall   = 1'b1;
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                // Leave on the edge that brings the counter to zero: WAIT lasts WAIT_CYCLES cycles
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= mem_addr;
                size_q  <= store_size;
                wdata_q <= mem_write_data;
            end
        end
    end

    assign stall_mem = stall & ~reset;

    // With zero wait states the commit edge is the accept edge, so the live inputs are used
    assign acc_addr  = (state_q == IDLE) ? mem_addr       : addr_q;
    assign acc_size  = (state_q == IDLE) ? store_size     : size_q;
    assign acc_wdata = (state_q == IDLE) ? mem_write_data : wdata_q;

    assign commit  = (state_d == DONE) && (state_q != DONE) && !reset;
    assign widx    = acc_addr[AW+1:2];
    assign is_read = (acc_size == SZ_READ);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign misaligned = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                        ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign do_write = commit && !is_read && !misaligned;

    always_comb begin
        lane_en   = '0;
        lane_data = '0;
        unique case (acc_size)
            SZ_BYTE: begin
                lane_en   = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            SZ_WORD: begin
                lane_en   = 4'b1111;
                lane_data = acc_wdata;
            end
            default: begin
                lane_en   = '0;
                lane_data = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    ram[widx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_shifted = ram[widx] >> {acc_addr[1:0], 3'b000};

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_read_data <= '0;
        end else if (commit) begin
            if (misaligned) begin
                mem_read_data <= '0;
            end else if (is_read) begin
                mem_read_data <= rd_shifted;
            end
        end
    end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= commit && misaligned;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

    // Address bits above the RAM index alias by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[31:AW+2];

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: byte-array memory model with per-cycle output checks,
// plus a small zero-wait-state instance exercised with directed accesses.
module tb_mem_responder;

    localparam int DEPTH0 = 256;
    localparam int W0     = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instance 0: default depth, two wait states
    logic        rst0, en0, st0, mis0;
    logic [1:0]  sz0;
    logic [31:0] a0, d0, rd0;

    mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(W0)) u0 (
        .CLK(CLK), .reset(rst0), .memory_en(en0), .store_size(sz0), .mem_addr(a0),
        .mem_write_data(d0), .mem_read_data(rd0), .stall_mem(st0), .misalign_err(mis0)
    );

    // Instance 1: small depth, zero wait states
    logic        rst1, en1, st1, mis1;
    logic [1:0]  sz1;
    logic [31:0] a1, d1, rd1;

    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u1 (
        .CLK(CLK), .reset(rst1), .memory_en(en1), .store_size(sz1), .mem_addr(a1),
        .mem_write_data(d1), .mem_read_data(rd1), .stall_mem(st1), .misalign_err(mis1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mm [0:4*DEPTH0-1];
    logic        exp_stall, exp_mis, chk_en;
    logic [31:0] exp_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("stall_mem", 32'(st0), 32'(exp_stall));
            chk("read_data", rd0, exp_rd);
            chk("misalign_err", 32'(mis0), 32'(exp_mis));
        end
    end

    // Reference: memory is a flat byte array indexed modulo its size
    task automatic model_apply(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd_new, output logic mis);
        int unsigned base, off;
        logic [31:0] w;
        rd_new = exp_rd;
        mis    = 1'b0;
        base   = ((a / 4) % DEPTH0) * 4;
        off    = a % 4;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if ((sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0)) begin
            rd_new = '0;
            mis    = 1'b1;
            return;
        end
`endif
        case (sz)
            2'd0: mm[base + off] = d[7:0];
            2'd1: begin
                mm[base + (off / 2) * 2]     = d[7:0];
                mm[base + (off / 2) * 2 + 1] = d[15:8];
            end
            2'd2: for (int i = 0; i < 4; i++) mm[base + i] = d[8*i +: 8];
            default: begin
                w      = {mm[base + 3], mm[base + 2], mm[base + 1], mm[base]};
                rd_new = w >> (8 * off);
            end
        endcase
    endtask

    task automatic scramble();
        en0 = 1'($urandom_range(0, 1));
        sz0 = 2'($urandom_range(0, 3));
        a0  = $urandom;
        d0  = $urandom;
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
        scramble();
        en0       = 1'b0;
        exp_stall = 1'b0;
        exp_mis   = 1'b0;
    endtask

    task automatic access(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd_new;
        logic        mis;
        @(posedge CLK); #1;
        en0 = 1'b1; sz0 = sz; a0 = a; d0 = d;
        exp_stall = 1'b1;
        exp_mis   = 1'b0;
        model_apply(sz, a, d, rd_new, mis);
        for (int k = 0; k < W0; k++) begin
            @(posedge CLK); #1;
            scramble();
        end
        @(posedge CLK); #1;
        scramble();
        exp_stall = 1'b0;
        exp_rd    = rd_new;
        exp_mis   = mis;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; en0 = 1'b0; sz0 = '0; a0 = '0; d0 = '0;
        rst1 = 1'b1; en1 = 1'b0; sz1 = '0; a1 = '0; d1 = '0;
        exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = '0; chk_en = 1'b1;
        @(posedge CLK); #1;
        en0 = 1'b1;   // stall must stay low while reset is high
        @(posedge CLK); #1;
        rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b0;

        for (int i = 0; i < DEPTH0; i++) access(2'd2, 32'(i * 4), $urandom);

        access(2'd2, 32'h10, 32'hDEADBEEF);
        access(2'd3, 32'h10, 32'h0);
        chk("word_rw_pin", rd0, 32'hDEADBEEF);
        access(2'd2, 32'h20, 32'h11223344);
        access(2'd0, 32'h22, 32'h000000AA);
        access(2'd3, 32'h20, 32'h0);
        chk("byte_merge_pin", rd0, 32'h11AA3344);
        access(2'd3, 32'h23, 32'h0);
        chk("byte_read_pin", rd0, 32'h00000011);
        idle_cycle();
        access(2'd2, 32'h400, 32'h5);
        access(2'd3, 32'h0, 32'h0);
        chk("wrap_pin", rd0, 32'h00000005);

        access(2'd2, 32'h30, 32'hCAFEF00D);
        access(2'd1, 32'h31, 32'h0000BEEF);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        chk("misalign_flag_pin", 32'(mis0), 32'h1);
        chk("misalign_rd_pin", rd0, 32'h0);
`endif
        access(2'd3, 32'h30, 32'h0);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        chk("misalign_nowrite_pin", rd0, 32'hCAFEF00D);
`else
        chk("half_aligned_pin", rd0, 32'hCAFEBEEF);
`endif

        for (int n = 0; n < 300; n++) begin
            access(2'($urandom_range(0, 3)), $urandom, $urandom);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        // Reset during WAIT must abort the pending write
        access(2'd2, 32'h30, 32'h0);
        @(posedge CLK); #1;
        en0 = 1'b1; sz0 = 2'd2; a0 = 32'h30; d0 = 32'hFFFFFFFF;
        exp_stall = 1'b1; exp_mis = 1'b0;
        @(posedge CLK); #1;
        rst0 = 1'b1; scramble();
        exp_stall = 1'b0; exp_rd = '0; exp_mis = 1'b0;
        @(posedge CLK); #1;
        scramble(); en0 = 1'b1;
        @(posedge CLK); #1;
        rst0 = 1'b0; en0 = 1'b0;
        access(2'd3, 32'h30, 32'h0);
        chk("reset_abort_pin", rd0, 32'h0);
        idle_cycle();

        // Zero-wait-state instance: one stall cycle, DONE ignores requests
        @(posedge CLK); #1;
        en1 = 1'b1; sz1 = 2'd2; a1 = 32'h8; d1 = 32'h12345678;
        @(negedge CLK); chk("w0_write_stall", 32'(st1), 32'h1);
        @(posedge CLK); #1;
        en1 = 1'b1; sz1 = 2'd3; a1 = 32'h0;
        @(negedge CLK); chk("w0_done_stall", 32'(st1), 32'h0);
        @(posedge CLK); #1;
        en1 = 1'b1; sz1 = 2'd3; a1 = 32'h8;
        @(negedge CLK); chk("w0_read_stall", 32'(st1), 32'h1);
        @(posedge CLK); #1;
        en1 = 1'b0;
        @(negedge CLK);
        chk("w0_read_done_stall", 32'(st1), 32'h0);
        chk("w0_raw_data", rd1, 32'h12345678);
        @(posedge CLK); #1;
        en1 = 1'b1; sz1 = 2'd3; a1 = 32'h4B;
        @(posedge CLK); #1;
        en1 = 1'b0;
        @(negedge CLK);
        chk("w0_wrap_byte", rd1, 32'h00000012);
        chk("w0_misalign", 32'(mis1), 32'h0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
